// File: rtl/udp_pkg.sv
// Shared encodings and constants for the UDP loopback buffer.
package udp_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_ECHO      = 2'b00,
    MODE_FIXED     = 2'b01,
    MODE_COUNT     = 2'b10,
    MODE_FIXED_ALT = 2'b11
  } mode_e;

  localparam int unsigned UDP_HDR_LEN     = 8;
  localparam logic [15:0] DEF_TOTAL_LEN_C = 16'd48;
  localparam logic [15:0] DEF_DATA_LEN_C  = 16'd28;

  // Encoding 11 is an alias of the fixed-message mode.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_FIXED : mode_e'(m);
  endfunction

endpackage

// File: rtl/udp_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module udp_dpram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              e_rxc,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Read sees the old word when the same address is written this cycle.
  always_comb rd_data_d = mem_q[rd_addr];

  always_ff @(posedge e_rxc) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge e_rxc) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_loopback_buf.sv
// UDP payload loopback buffer: preloads a message, stores received payload,
// and serves it (or a fixed/counter pattern) back through a tx request handshake.
//
// state   | meaning
// INIT    | writing the default message into RAM, one word per cycle
// IDLE    | waiting for an accepted packet; mode register tracks the mode input
// PEND    | tx_req asserted, waiting for tx_ack
module udp_loopback_buf
  import udp_pkg::*;
#(
  parameter int unsigned                    DATA_W        = 32,
  parameter int unsigned                    ADDR_W        = 9,
  parameter int unsigned                    DEF_WORDS     = 5,
  parameter logic [DEF_WORDS*DATA_W-1:0]    DEF_MSG       = "HELLO ALINX AX516 \n\r",
  parameter logic [15:0]                    DEF_TOTAL_LEN = DEF_TOTAL_LEN_C,
  parameter logic [15:0]                    DEF_DATA_LEN  = DEF_DATA_LEN_C
) (
  input  logic              e_rxc,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] rx_wr_addr,
  input  logic [DATA_W-1:0] rx_wr_data,
  input  logic              rx_done,
  input  logic [15:0]       rx_total_length,
  input  logic [15:0]       rx_data_length,
  input  logic [ADDR_W-1:0] tx_rd_addr,
  output logic [DATA_W-1:0] tx_rd_data,
  output logic [15:0]       tx_total_length,
  output logic [15:0]       tx_data_length,
  output logic              tx_req,
  input  logic              tx_ack,
  output logic              init_done,
  output logic              overflow,
  output logic [15:0]       pkt_count
);

  localparam int unsigned       DEPTH       = 2**ADDR_W;
  localparam int unsigned       BYTES_W     = DATA_W / 8;
  localparam logic [63:0]       MAX_PAYLOAD = 64'(DEPTH) * 64'(BYTES_W);
  localparam logic [ADDR_W-1:0] INIT_LAST   = ADDR_W'(DEF_WORDS - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  mode_e             rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] init_left_q, init_left_d;
  logic              init_done_q, init_done_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic [15:0]       tx_total_q, tx_total_d;
  logic [15:0]       tx_data_q, tx_data_d;
  logic [DATA_W-1:0] alt_q, alt_d;

  logic              init_last;
  logic              pkt_ok;
  logic              pkt_accept;
  logic              ack_take;
  logic [15:0]       payload_len;
  logic [DATA_W-1:0] cnt_word;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rd_data;

  // Default message as a ROM covering the full address space (zero past the message).
  logic [DATA_W-1:0] def_rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    if (g < DEF_WORDS) begin : g_msg
      assign def_rom[g] = DEF_MSG[(DEF_WORDS-1-g)*DATA_W +: DATA_W];
    end else begin : g_zero
      assign def_rom[g] = '0;
    end
  end

  always_comb begin
    payload_len = rx_data_length - 16'(UDP_HDR_LEN);
    pkt_ok      = (rx_data_length >= 16'(UDP_HDR_LEN)) && (64'(payload_len) <= MAX_PAYLOAD);
    pkt_accept  = rx_done && pkt_ok && (state_q != ST_INIT);
    init_last   = (init_left_q == '0);
    ack_take    = (state_q == ST_PEND) && tx_ack;
  end

  // FSM: state register
  always_ff @(posedge e_rxc) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // FSM: next state; a packet arriving with tx_ack keeps the request alive
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (init_last)             state_d = ST_IDLE;
      ST_IDLE: if (pkt_accept)            state_d = ST_PEND;
      ST_PEND: if (!pkt_accept && tx_ack) state_d = ST_IDLE;
      default:                            state_d = ST_INIT;
    endcase
  end

  // FSM: outputs and RAM write-port steering
  always_comb begin
    tx_req    = (state_q == ST_PEND);
    ram_we    = rx_valid;
    ram_waddr = rx_wr_addr;
    ram_wdata = rx_wr_data;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = INIT_LAST - init_left_q;
      ram_wdata = def_rom[INIT_LAST - init_left_q];
    end
  end

  always_comb begin
    init_left_d = init_left_q;
    if ((state_q == ST_INIT) && !init_last) init_left_d = init_left_q - 1'b1;

    init_done_d = init_done_q | ((state_q == ST_INIT) && init_last);
    mode_d      = (state_q == ST_IDLE) ? norm_mode(mode) : mode_q;
    overflow_d  = overflow_q | (rx_done && !pkt_ok);
    pkt_count_d = ack_take ? pkt_count_q + 16'd1 : pkt_count_q;

    tx_total_d = tx_total_q;
    tx_data_d  = tx_data_q;
    if (pkt_accept) begin
      if (mode_q == MODE_ECHO) begin
        tx_total_d = rx_total_length;
        tx_data_d  = rx_data_length;
      end else begin
        tx_total_d = DEF_TOTAL_LEN;
        tx_data_d  = DEF_DATA_LEN;
      end
    end

    // Non-echo read data is computed here and registered alongside the RAM read.
    cnt_word = DATA_W'({pkt_count_q, 16'h0000}) + DATA_W'(tx_rd_addr);
    alt_d    = (mode_q == MODE_COUNT) ? cnt_word : def_rom[tx_rd_addr];
    rd_sel_d = mode_q;
  end

  always_ff @(posedge e_rxc) begin
    if (reset) begin
      mode_q      <= MODE_ECHO;
      rd_sel_q    <= MODE_ECHO;
      init_left_q <= INIT_LAST;
      init_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      pkt_count_q <= '0;
      tx_total_q  <= DEF_TOTAL_LEN;
      tx_data_q   <= DEF_DATA_LEN;
      alt_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      rd_sel_q    <= rd_sel_d;
      init_left_q <= init_left_d;
      init_done_q <= init_done_d;
      overflow_q  <= overflow_d;
      pkt_count_q <= pkt_count_d;
      tx_total_q  <= tx_total_d;
      tx_data_q   <= tx_data_d;
      alt_q       <= alt_d;
    end
  end

  udp_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .e_rxc   (e_rxc),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (tx_rd_addr),
    .rd_data (ram_rd_data)
  );

  assign tx_rd_data      = (rd_sel_q == MODE_ECHO) ? ram_rd_data : alt_q;
  assign tx_total_length = tx_total_q;
  assign tx_data_length  = tx_data_q;
  assign init_done       = init_done_q;
  assign overflow        = overflow_q;
  assign pkt_count       = pkt_count_q;

endmodule

// File: tb/tb_udp_loopback_buf.sv
// Self-checking bench for udp_loopback_buf: vector table for packet handling,
// hand sequences for preload, read modes, collisions and reset during PEND.
module tb_udp_loopback_buf;

  logic        e_rxc = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        rx_valid = 1'b0;
  logic [8:0]  rx_wr_addr = '0;
  logic [31:0] rx_wr_data = '0;
  logic        rx_done = 1'b0;
  logic [15:0] rx_total_length = '0;
  logic [15:0] rx_data_length = '0;
  logic [8:0]  tx_rd_addr = '0;
  logic [31:0] tx_rd_data;
  logic [15:0] tx_total_length;
  logic [15:0] tx_data_length;
  logic        tx_req;
  logic        tx_ack = 1'b0;
  logic        init_done;
  logic        overflow;
  logic [15:0] pkt_count;

  udp_loopback_buf dut (
    .e_rxc           (e_rxc),
    .reset           (reset),
    .mode            (mode),
    .rx_valid        (rx_valid),
    .rx_wr_addr      (rx_wr_addr),
    .rx_wr_data      (rx_wr_data),
    .rx_done         (rx_done),
    .rx_total_length (rx_total_length),
    .rx_data_length  (rx_data_length),
    .tx_rd_addr      (tx_rd_addr),
    .tx_rd_data      (tx_rd_data),
    .tx_total_length (tx_total_length),
    .tx_data_length  (tx_data_length),
    .tx_req          (tx_req),
    .tx_ack          (tx_ack),
    .init_done       (init_done),
    .overflow        (overflow),
    .pkt_count       (pkt_count)
  );

  always #5 e_rxc = ~e_rxc;

  typedef struct {
    logic [1:0]  mode;
    logic        done;
    logic [15:0] tot;
    logic [15:0] dl;
    logic        ack;
    logic        exp_req;
    logic [15:0] exp_tot;
    logic [15:0] exp_dl;
    logic [15:0] exp_cnt;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic        req;
    logic [15:0] tot;
    logic [15:0] dl;
    logic [15:0] cnt;
    logic        ovf;
  } op_exp_t;

  vec_t        vecs [16];
  op_exp_t     op_q [$];
  logic [31:0] rd_q [$];
  logic [31:0] msg_w [5];

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge e_rxc);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic req, input logic [15:0] tot,
                            input logic [15:0] dl, input logic [15:0] cnt, input logic ovf);
    chk({tag, "_req"}, 32'(tx_req), 32'(req));
    chk({tag, "_tot"}, 32'(tx_total_length), 32'(tot));
    chk({tag, "_dl"},  32'(tx_data_length), 32'(dl));
    chk({tag, "_cnt"}, 32'(pkt_count), 32'(cnt));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic rd_check(input logic [8:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] want;
    tx_rd_addr = addr;
    rd_q.push_back(exp);
    tick();
    want = rd_q.pop_front();
    chk(name, tx_rd_data, want);
  endtask

  task automatic apply_vec(input int i);
    vec_t    v;
    op_exp_t e;
    v = vecs[i];
    mode = v.mode;
    tick();
    rx_done         = v.done;
    rx_total_length = v.tot;
    rx_data_length  = v.dl;
    tx_ack          = v.ack;
    op_q.push_back('{v.exp_req, v.exp_tot, v.exp_dl, v.exp_cnt, v.exp_ovf});
    tick();
    rx_done = 1'b0;
    tx_ack  = 1'b0;
    e = op_q.pop_front();
    chk_status($sformatf("vec%0d", i), e.req, e.tot, e.dl, e.cnt, e.ovf);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    chk({tag, "_init_cycles"}, 32'(n), 32'd5);
  endtask

  task automatic rx_write(input logic [8:0] addr, input logic [31:0] data);
    rx_valid   = 1'b1;
    rx_wr_addr = addr;
    rx_wr_data = data;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    msg_w[0] = 32'h48454C4C;
    msg_w[1] = 32'h4F20414C;
    msg_w[2] = 32'h494E5820;
    msg_w[3] = 32'h41583531;
    msg_w[4] = 32'h36200A0D;

    //          mode  done tot       dl        ack   req   tot       dl        cnt     ovf
    vecs[0]  = '{2'd0, 1'b1, 16'd40,   16'd7,    1'b0, 1'b0, 16'd48,   16'd28,   16'd0, 1'b1};
    vecs[1]  = '{2'd0, 1'b1, 16'd2080, 16'd2060, 1'b0, 1'b0, 16'd48,   16'd28,   16'd0, 1'b1};
    vecs[2]  = '{2'd0, 1'b1, 16'd2076, 16'd2056, 1'b0, 1'b1, 16'd2076, 16'd2056, 16'd1, 1'b1};
    vecs[3]  = '{2'd0, 1'b0, 16'd0,    16'd0,    1'b1, 1'b0, 16'd2076, 16'd2056, 16'd2, 1'b1};
    vecs[4]  = '{2'd1, 1'b1, 16'd100,  16'd60,   1'b0, 1'b1, 16'd48,   16'd28,   16'd2, 1'b1};
    vecs[5]  = '{2'd1, 1'b1, 16'd33,   16'd13,   1'b1, 1'b1, 16'd48,   16'd28,   16'd3, 1'b1};
    vecs[6]  = '{2'd1, 1'b0, 16'd0,    16'd0,    1'b1, 1'b0, 16'd48,   16'd28,   16'd4, 1'b1};
    vecs[7]  = '{2'd2, 1'b1, 16'd9,    16'd9,    1'b0, 1'b1, 16'd48,   16'd28,   16'd4, 1'b1};
    vecs[8]  = '{2'd0, 1'b0, 16'd0,    16'd0,    1'b1, 1'b0, 16'd48,   16'd28,   16'd5, 1'b1};
    vecs[9]  = '{2'd0, 1'b1, 16'd50,   16'd30,   1'b0, 1'b1, 16'd50,   16'd30,   16'd5, 1'b1};
    vecs[10] = '{2'd0, 1'b1, 16'd60,   16'd40,   1'b1, 1'b1, 16'd60,   16'd40,   16'd6, 1'b1};
    vecs[11] = '{2'd0, 1'b0, 16'd0,    16'd0,    1'b1, 1'b0, 16'd60,   16'd40,   16'd7, 1'b1};
    vecs[12] = '{2'd0, 1'b0, 16'd0,    16'd0,    1'b1, 1'b0, 16'd60,   16'd40,   16'd7, 1'b1};
    vecs[13] = '{2'd0, 1'b1, 16'd10,   16'd7,    1'b0, 1'b0, 16'd60,   16'd40,   16'd7, 1'b1};
    vecs[14] = '{2'd0, 1'b1, 16'd20,   16'd8,    1'b0, 1'b1, 16'd20,   16'd8,    16'd7, 1'b1};
    vecs[15] = '{2'd0, 1'b0, 16'd0,    16'd0,    1'b1, 1'b0, 16'd20,   16'd8,    16'd8, 1'b1};

    // Reset state and preload timing
    reset = 1'b1;
    repeat (3) tick();
    chk_status("rst", 1'b0, 16'd48, 16'd28, 16'd0, 1'b0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rd_data", tx_rd_data, 32'd0);
    reset = 1'b0;
    wait_init("boot");

    for (int i = 0; i < 5; i++) rd_check(9'(i), msg_w[i], $sformatf("preload_rd%0d", i));

    // Rejected packets: too short, one word too many
    for (int i = 0; i < 2; i++) apply_vec(i);

    // Echo packet
    rx_write(9'd0, 32'hDEADBEEF);
    rx_write(9'd1, 32'h01234567);
    rx_write(9'd2, 32'hA5A5A5A5);
    rx_done = 1'b1; rx_total_length = 16'd31; rx_data_length = 16'd11;
    tick();
    rx_done = 1'b0;
    chk_status("echo_pend", 1'b1, 16'd31, 16'd11, 16'd0, 1'b1);
    rd_check(9'd0, 32'hDEADBEEF, "echo_rd0");
    rd_check(9'd1, 32'h01234567, "echo_rd1");
    rd_check(9'd2, 32'hA5A5A5A5, "echo_rd2");
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk_status("echo_ack", 1'b0, 16'd31, 16'd11, 16'd1, 1'b1);

    // Largest acceptable packet, then ack
    for (int i = 2; i < 4; i++) apply_vec(i);

    // Counter and fixed-message read modes
    mode = 2'd2;
    tick();
    rd_check(9'd5,   32'h00020005, "cnt_rd5");
    rd_check(9'h1FF, 32'h000201FF, "cnt_rd511");
    mode = 2'd1;
    tick();
    for (int i = 0; i < 5; i++) rd_check(9'(i), msg_w[i], $sformatf("fixed_rd%0d", i));
    rd_check(9'd5,   32'd0, "fixed_rd5");
    rd_check(9'h1FF, 32'd0, "fixed_rd511");
    mode = 2'd3;
    tick();
    rd_check(9'd2, msg_w[2], "mode3_rd2");

    for (int i = 4; i < 8; i++) apply_vec(i);

    // Mode change while PEND must not take effect yet
    mode = 2'd0;
    tick();
    rd_check(9'd5, 32'h00040005, "pend_mode_hold");

    for (int i = 8; i < 16; i++) apply_vec(i);

    // Read-before-write on an address collision
    rx_write(9'd7, 32'h11111111);
    rx_valid = 1'b1; rx_wr_addr = 9'd7; rx_wr_data = 32'h22222222;
    rd_check(9'd7, 32'h11111111, "collide_old");
    rx_valid = 1'b0;
    rd_check(9'd7, 32'h22222222, "collide_new");

    // Reset while PEND
    rx_done = 1'b1; rx_total_length = 16'd40; rx_data_length = 16'd20;
    tick();
    rx_done = 1'b0;
    chk_status("pre_rst_pend", 1'b1, 16'd40, 16'd20, 16'd8, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_status("mid_rst", 1'b0, 16'd48, 16'd28, 16'd0, 1'b0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    wait_init("reboot");
    rd_check(9'd7, 32'h22222222, "reboot_rd7");
    rd_check(9'd0, msg_w[0], "reboot_rd0");
    rd_check(9'd2, msg_w[2], "reboot_rd2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_loopback_buf.md
UDP_LOOPBACK_BUF -- requirements
Module: udp_loopback_buf

Interface
REQ-001 Parameters: DATA_W, default 32, RAM word width in bits (multiple of 8); ADDR_W, default 9, RAM depth = 2**ADDR_W words; DEF_WORDS, default 5, preload message length in words (1..2**ADDR_W); DEF_MSG, default "HELLO ALINX AX516 \n\r" packed word 0 in MSBs, DEF_WORDS*DATA_W bits; DEF_TOTAL_LEN, default 48; DEF_DATA_LEN, default 28.
REQ-002 Ports: e_rxc in 1, sole clock (rising edge); reset in 1, synchronous active-high reset.
REQ-003 Ports: mode in 2, 00 echo / 01 fixed message / 10 counter pattern / 11 treated as 01.
REQ-004 Ports: rx_valid in 1, rx_wr_addr in ADDR_W, rx_wr_data in DATA_W -- received payload word write strobe, address and data.
REQ-005 Ports: rx_done in 1, one-cycle pulse at packet end; rx_total_length in 16 and rx_data_length in 16 are valid while rx_done=1.
REQ-006 Ports: tx_rd_addr in ADDR_W, tx_rd_data out DATA_W -- transmit payload read port.
REQ-007 Ports: tx_total_length out 16, tx_data_length out 16 -- lengths for the pending packet.
REQ-008 Ports: tx_req out 1, tx_ack in 1 -- transmit request/acknowledge handshake.
REQ-009 Ports: init_done out 1, overflow out 1 (sticky), pkt_count out 16 (packets acknowledged).

Function
REQ-010 FSM states: INIT, IDLE, PEND; reset enters INIT.
REQ-011 INIT: write DEF_MSG word k to RAM address k, one per cycle, k=0..DEF_WORDS-1; after the last write go to IDLE and set init_done=1 (init_done rises DEF_WORDS cycles after reset deasserts).
REQ-012 rx_valid writes in INIT are ignored; in IDLE/PEND rx_valid=1 writes rx_wr_data to rx_wr_addr in the same cycle.
REQ-013 Packet accept check on rx_done: payload bytes P = rx_data_length-8; accept iff rx_data_length>=8 and ceil(P/(DATA_W/8)) <= 2**ADDR_W.
REQ-014 Rejected packet: overflow set to 1 until reset, lengths and state unchanged, no tx_req.
REQ-015 Accepted packet in IDLE or PEND: latch rx_total_length/rx_data_length into tx_total_length/tx_data_length next cycle, enter PEND, tx_req=1.
REQ-016 Modes 01/10 use DEF_TOTAL_LEN/DEF_DATA_LEN instead of the received lengths; acceptance check still applies.
REQ-017 PEND: tx_req held 1 until tx_ack=1; then IDLE, tx_req=0, pkt_count+1 (wraps 16'hFFFF->0).
REQ-018 tx_ack=1 in the same cycle as an accepted rx_done: rx_done wins -- stay PEND, tx_req stays 1, new lengths latched, pkt_count still +1.
REQ-019 tx_ack while tx_req=0 is ignored.
REQ-020 Mode sampled into an internal register only in IDLE; changes while PEND/INIT take effect on the next IDLE cycle.
REQ-021 tx_rd_data registered, 1-cycle latency from tx_rd_addr, read in every state.
REQ-022 Mode 00: RAM contents at tx_rd_addr (read-before-write on address collision).
REQ-023 Mode 01: DEF_MSG word tx_rd_addr if tx_rd_addr<DEF_WORDS, else 0.
REQ-024 Mode 10: {pkt_count, 16'b0} + tx_rd_addr, truncated/zero-extended to DATA_W, computed modulo 2**DATA_W.

Reset
REQ-025 Reset values: tx_req=0, init_done=0, overflow=0, pkt_count=0, tx_rd_data=0, tx_total_length=DEF_TOTAL_LEN, tx_data_length=DEF_DATA_LEN, mode register=00, state=INIT.
REQ-026 Reset asserted mid-INIT or mid-PEND: abandon immediately and restart preload from address 0; RAM contents beyond DEF_WORDS are not cleared.

Structure
REQ-027 Shared package udp_pkg holds state encoding, mode encoding, UDP header length constant (8), default lengths.
REQ-028 One sub-module udp_dpram: simple dual-port RAM, one write port, one registered read port, DATA_W x 2**ADDR_W, single clock e_rxc.

Verification
REQ-029 Reset release, defaults -> init_done rises after 5 cycles; addr 0..4 in mode 00 read 0x48454C4C,0x4F20414C,0x494E5820,0x41583531,0x36200A0D.
REQ-030 Mode 00, write 3 words at 0..2, rx_done with total 31, data 11 -> tx_req=1, lengths 31/11, read returns written words; tx_ack -> tx_req=0, pkt_count=1.
REQ-031 rx_done with rx_data_length=7, then with rx_data_length=8+4*513 (ADDR_W=9) -> overflow=1, no tx_req, lengths stay 48/28.
REQ-032 Mode 10, pkt_count=2, tx_rd_addr=5 -> tx_rd_data=0x00020005 one cycle later.
REQ-033 Accepted rx_done and tx_ack in the same cycle -> tx_req stays 1, new lengths latched, pkt_count increments.
REQ-034 Reset pulsed while PEND -> tx_req=0, pkt_count=0, preload repeats, init_done low for DEF_WORDS cycles.
